// File: rtl/mctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset controller.
package mctrl_pkg;

  typedef enum logic [3:0] {
    ST_RST      = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_MEM_ADDR = 4'd3,
    ST_MEM_RD   = 4'd4,
    ST_MEM_WB   = 4'd5,
    ST_MEM_WR   = 4'd6,
    ST_EXEC_R   = 4'd7,
    ST_R_WB     = 4'd8,
    ST_EXEC_I   = 4'd9,
    ST_I_WB     = 4'd10,
    ST_BRANCH   = 4'd11,
    ST_JUMP     = 4'd12,
    ST_HALT     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BGT   = 6'h05;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;

  localparam logic [1:0] ALUB_REGB    = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_XOR   = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_we;
    logic       ir_we;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic       sign_zero;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  // States that own the memory port and may wait on mem_ready.
  function automatic logic is_mem_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/mctrl_if.sv
// Controller <-> datapath bundle: IR fields and ALU flags in, per-cycle controls out.
interface mctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       gt;
  logic       mem_ready;
  logic       pc_we, ir_we, i_or_d, mem_read, mem_write, mem_to_reg;
  logic       reg_dst, reg_write, alu_src_a, sign_zero;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic       instr_done, illegal_op, mem_timeout;

  modport master (
    input  opcode, funct, zero, gt, mem_ready,
    output pc_we, ir_we, i_or_d, mem_read, mem_write, mem_to_reg,
           reg_dst, reg_write, alu_src_a, sign_zero,
           alu_src_b, alu_op, pc_src, instr_done, illegal_op, mem_timeout
  );

  modport slave (
    output opcode, funct, zero, gt, mem_ready,
    input  pc_we, ir_we, i_or_d, mem_read, mem_write, mem_to_reg,
           reg_dst, reg_write, alu_src_a, sign_zero,
           alu_src_b, alu_op, pc_src, instr_done, illegal_op, mem_timeout
  );
endinterface

// File: rtl/mctrl_wait_timer.sv
// Memory wait-cycle counter; expired flags the last permitted wait cycle.
module mctrl_wait_timer #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(WAIT_LIMIT + 1);

  logic [CW-1:0] cnt_r;

  // Wait counter: clear has priority over counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {CW{1'b0}};
    end else if (clear) begin
      cnt_r <= {CW{1'b0}};
    end else if (enable) begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (cnt_r == CW'(WAIT_LIMIT - 1));
endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle Moore sequencer for the MIPS-subset datapath.
// Optional memory wait/timeout support is built when MCTRL_MEM_HANDSHAKE_EN is defined.
module multicycle_ctrl
  import mctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 15
) (
  input  logic     clk,
  input  logic     reset,
  mctrl_if.master  bus
);
  state_t state_r, state_nxt_s;
  ctrl_t  ctrl_s;
  logic   ready_s;
  logic   expired_s;

`ifdef MCTRL_MEM_HANDSHAKE_EN
  logic mem_state_s;
  logic timeout_r;

  assign ready_s     = bus.mem_ready;
  assign mem_state_s = is_mem_state(state_r);

  mctrl_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (!mem_state_s || bus.mem_ready),
    .enable  (mem_state_s && !bus.mem_ready),
    .expired (expired_s)
  );

  // Sticky timeout flag, set on the edge that enters HALT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_r <= 1'b0;
    end else if (state_nxt_s == ST_HALT) begin
      timeout_r <= 1'b1;
    end else begin
      timeout_r <= timeout_r;
    end
  end

  assign bus.mem_timeout = timeout_r;
`else
  logic unused_s;
  assign ready_s         = 1'b1;
  assign expired_s       = 1'b0;
  assign bus.mem_timeout = 1'b0;
  assign unused_s        = bus.mem_ready & (WAIT_LIMIT > 32'sd0);
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_RST;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and Moore outputs; memory states stall until ready or timeout.
  always_comb begin
    state_nxt_s = state_r;
    ctrl_s      = '0;
    case (state_r)
      ST_RST: begin
        state_nxt_s = ST_FETCH;
      end
      ST_FETCH: begin
        ctrl_s.mem_read  = 1'b1;
        ctrl_s.alu_src_b = ALUB_FOUR;
        ctrl_s.alu_op    = ALU_ADD;
        ctrl_s.pc_src    = PC_ALU;
        if (ready_s) begin
          ctrl_s.pc_we = 1'b1;
          ctrl_s.ir_we = 1'b1;
          state_nxt_s  = ST_DECODE;
        end else if (expired_s) begin
          state_nxt_s = ST_HALT;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        ctrl_s.alu_src_b = ALUB_IMM_SH2;
        case (bus.opcode)
          OP_RTYPE:      state_nxt_s = ST_EXEC_R;
          OP_LW, OP_SW:  state_nxt_s = ST_MEM_ADDR;
          OP_BEQ, OP_BGT: state_nxt_s = ST_BRANCH;
          OP_XORI:       state_nxt_s = ST_EXEC_I;
          OP_J:          state_nxt_s = ST_JUMP;
          default: begin
            ctrl_s.illegal_op = 1'b1;
            ctrl_s.instr_done = 1'b1;
            state_nxt_s       = ST_FETCH;
          end
        endcase
      end
      ST_MEM_ADDR: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = ALUB_IMM;
        ctrl_s.alu_op    = ALU_ADD;
        if (bus.opcode == OP_LW) begin
          state_nxt_s = ST_MEM_RD;
        end else begin
          state_nxt_s = ST_MEM_WR;
        end
      end
      ST_MEM_RD: begin
        ctrl_s.i_or_d   = 1'b1;
        ctrl_s.mem_read = 1'b1;
        if (ready_s) begin
          state_nxt_s = ST_MEM_WB;
        end else if (expired_s) begin
          state_nxt_s = ST_HALT;
        end else begin
          state_nxt_s = ST_MEM_RD;
        end
      end
      ST_MEM_WB: begin
        ctrl_s.mem_to_reg = 1'b1;
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.instr_done = 1'b1;
        state_nxt_s       = ST_FETCH;
      end
      ST_MEM_WR: begin
        ctrl_s.i_or_d    = 1'b1;
        ctrl_s.mem_write = 1'b1;
        if (ready_s) begin
          ctrl_s.instr_done = 1'b1;
          state_nxt_s       = ST_FETCH;
        end else if (expired_s) begin
          state_nxt_s = ST_HALT;
        end else begin
          state_nxt_s = ST_MEM_WR;
        end
      end
      ST_EXEC_R: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_op    = ALU_FUNCT;
        // Shifts take shamt through the immediate path.
        if ((bus.funct == FN_SLL) || (bus.funct == FN_SRL)) begin
          ctrl_s.alu_src_b = ALUB_IMM;
        end else begin
          ctrl_s.alu_src_b = ALUB_REGB;
        end
        state_nxt_s = ST_R_WB;
      end
      ST_R_WB: begin
        ctrl_s.reg_dst    = 1'b1;
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.instr_done = 1'b1;
        state_nxt_s       = ST_FETCH;
      end
      ST_EXEC_I: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = ALUB_IMM;
        ctrl_s.alu_op    = ALU_XOR;
        ctrl_s.sign_zero = 1'b1;
        state_nxt_s      = ST_I_WB;
      end
      ST_I_WB: begin
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.instr_done = 1'b1;
        state_nxt_s       = ST_FETCH;
      end
      ST_BRANCH: begin
        ctrl_s.alu_src_a  = 1'b1;
        ctrl_s.alu_src_b  = ALUB_REGB;
        ctrl_s.alu_op     = ALU_SUB;
        ctrl_s.pc_src     = PC_ALUOUT;
        ctrl_s.instr_done = 1'b1;
        if (bus.opcode == OP_BEQ) begin
          ctrl_s.pc_we = bus.zero;
        end else if (bus.opcode == OP_BGT) begin
          ctrl_s.pc_we = bus.gt;
        end else begin
          ctrl_s.pc_we = 1'b0;
        end
        state_nxt_s = ST_FETCH;
      end
      ST_JUMP: begin
        ctrl_s.pc_src     = PC_JUMP;
        ctrl_s.pc_we      = 1'b1;
        ctrl_s.instr_done = 1'b1;
        state_nxt_s       = ST_FETCH;
      end
`ifdef MCTRL_MEM_HANDSHAKE_EN
      ST_HALT: begin
        state_nxt_s = ST_HALT;
      end
`endif
      default: begin
        state_nxt_s = ST_RST;
      end
    endcase
  end

  assign bus.pc_we      = ctrl_s.pc_we;
  assign bus.ir_we      = ctrl_s.ir_we;
  assign bus.i_or_d     = ctrl_s.i_or_d;
  assign bus.mem_read   = ctrl_s.mem_read;
  assign bus.mem_write  = ctrl_s.mem_write;
  assign bus.mem_to_reg = ctrl_s.mem_to_reg;
  assign bus.reg_dst    = ctrl_s.reg_dst;
  assign bus.reg_write  = ctrl_s.reg_write;
  assign bus.alu_src_a  = ctrl_s.alu_src_a;
  assign bus.sign_zero  = ctrl_s.sign_zero;
  assign bus.alu_src_b  = ctrl_s.alu_src_b;
  assign bus.alu_op     = ctrl_s.alu_op;
  assign bus.pc_src     = ctrl_s.pc_src;
  assign bus.instr_done = ctrl_s.instr_done;
  assign bus.illegal_op = ctrl_s.illegal_op;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl; timeout/wait steps run when MCTRL_MEM_HANDSHAKE_EN is defined.
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mctrl_if bus ();

  multicycle_ctrl #(.WAIT_LIMIT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {pc_we,ir_we,i_or_d,mem_read,mem_write,mem_to_reg,reg_dst,reg_write,alu_src_a,sign_zero,
  //  alu_src_b[2],alu_op[2],pc_src[2],instr_done,illegal_op,mem_timeout}
  localparam logic [18:0] C_ZERO    = 19'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0_0;
  localparam logic [18:0] C_FETCH   = 19'b1_1_0_1_0_0_0_0_0_0_01_00_00_0_0_0;
  localparam logic [18:0] C_DECODE  = 19'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0_0;
  localparam logic [18:0] C_DEC_ILL = 19'b0_0_0_0_0_0_0_0_0_0_11_00_00_1_1_0;
  localparam logic [18:0] C_EXR     = 19'b0_0_0_0_0_0_0_0_1_0_00_10_00_0_0_0;
  localparam logic [18:0] C_EXR_SH  = 19'b0_0_0_0_0_0_0_0_1_0_10_10_00_0_0_0;
  localparam logic [18:0] C_RWB     = 19'b0_0_0_0_0_0_1_1_0_0_00_00_00_1_0_0;
  localparam logic [18:0] C_MADDR   = 19'b0_0_0_0_0_0_0_0_1_0_10_00_00_0_0_0;
  localparam logic [18:0] C_MRD     = 19'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0_0;
  localparam logic [18:0] C_MWB     = 19'b0_0_0_0_0_1_0_1_0_0_00_00_00_1_0_0;
  localparam logic [18:0] C_MWR     = 19'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0_0;
  localparam logic [18:0] C_EXI     = 19'b0_0_0_0_0_0_0_0_1_1_10_11_00_0_0_0;
  localparam logic [18:0] C_IWB     = 19'b0_0_0_0_0_0_0_1_0_0_00_00_00_1_0_0;
  localparam logic [18:0] C_BR_T    = 19'b1_0_0_0_0_0_0_0_1_0_00_01_01_1_0_0;
  localparam logic [18:0] C_BR_N    = 19'b0_0_0_0_0_0_0_0_1_0_00_01_01_1_0_0;
  localparam logic [18:0] C_JUMP    = 19'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0_0;
`ifdef MCTRL_MEM_HANDSHAKE_EN
  localparam logic [18:0] C_FETCH_W = 19'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0_0;
  localparam logic [18:0] C_MWR_W   = 19'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0_0;
  localparam logic [18:0] C_HALT    = 19'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0_1;
`endif

  function automatic logic [18:0] obs_ctl();
    return {bus.pc_we, bus.ir_we, bus.i_or_d, bus.mem_read, bus.mem_write, bus.mem_to_reg,
            bus.reg_dst, bus.reg_write, bus.alu_src_a, bus.sign_zero, bus.alu_src_b,
            bus.alu_op, bus.pc_src, bus.instr_done, bus.illegal_op, bus.mem_timeout};
  endfunction

  task automatic chk(input string tag, input logic [18:0] exp);
    logic [18:0] o;
    o = obs_ctl();
    checks++;
    assert (o === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, o, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  // Called while in FETCH: loads the instruction fields, checks FETCH and DECODE.
  task automatic fetch(input logic [5:0] op, input logic [5:0] fn, input string tag);
    bus.opcode    = op;
    bus.funct     = fn;
    bus.mem_ready = 1'b1;
    #1;
    chk({tag, ".fetch"}, C_FETCH);
    nxt();
    chk({tag, ".decode"}, C_DECODE);
    nxt();
  endtask

  initial begin
    reset         = 1'b1;
    bus.opcode    = 6'h00;
    bus.funct     = 6'h00;
    bus.zero      = 1'b0;
    bus.gt        = 1'b0;
    bus.mem_ready = 1'b1;
    nxt();
    chk("reset", C_ZERO);
    reset = 1'b0;
    #1;
    chk("rst_state", C_ZERO);
    nxt();

    fetch(6'h00, 6'h20, "add");
    chk("add.exec", C_EXR);
    nxt();
    chk("add.wb", C_RWB);
    nxt();

    fetch(6'h00, 6'h00, "sll");
    chk("sll.exec", C_EXR_SH);
    nxt();
    chk("sll.wb", C_RWB);
    nxt();

    fetch(6'h00, 6'h02, "srl");
    chk("srl.exec", C_EXR_SH);
    nxt();
    nxt();

    fetch(6'h23, 6'h00, "lw");
    chk("lw.addr", C_MADDR);
    nxt();
    bus.mem_ready = 1'b0;
    #1;
`ifdef MCTRL_MEM_HANDSHAKE_EN
    for (int i = 0; i < 3; i++) begin
      chk("lw.rd_wait", C_MRD);
      nxt();
    end
    bus.mem_ready = 1'b1;
    #1;
`endif
    chk("lw.rd", C_MRD);
    nxt();
    chk("lw.wb", C_MWB);
    nxt();

    bus.opcode    = 6'h2B;
    bus.mem_ready = 1'b0;
    #1;
`ifdef MCTRL_MEM_HANDSHAKE_EN
    chk("sw.fetch_wait", C_FETCH_W);
    nxt();
    fetch(6'h2B, 6'h00, "sw");
`else
    chk("sw.fetch_ready_ignored", C_FETCH);
    nxt();
    chk("sw.decode", C_DECODE);
    nxt();
    bus.mem_ready = 1'b1;
`endif
    chk("sw.addr", C_MADDR);
    nxt();
    chk("sw.wr", C_MWR);
    nxt();

    fetch(6'h0E, 6'h00, "xori");
    chk("xori.exec", C_EXI);
    nxt();
    chk("xori.wb", C_IWB);
    nxt();

    fetch(6'h04, 6'h00, "beq_t");
    bus.zero = 1'b1; bus.gt = 1'b0; #1;
    chk("beq.taken", C_BR_T);
    nxt();
    fetch(6'h04, 6'h00, "beq_n");
    bus.zero = 1'b0; bus.gt = 1'b1; #1;
    chk("beq.not_taken", C_BR_N);
    nxt();
    fetch(6'h05, 6'h00, "bgt_t");
    bus.zero = 1'b0; bus.gt = 1'b1; #1;
    chk("bgt.taken", C_BR_T);
    nxt();
    fetch(6'h05, 6'h00, "bgt_n");
    bus.zero = 1'b1; bus.gt = 1'b0; #1;
    chk("bgt.not_taken", C_BR_N);
    nxt();

    fetch(6'h02, 6'h00, "j");
    chk("j.jump", C_JUMP);
    nxt();

    bus.opcode = 6'h3F;
    #1;
    chk("ill.fetch", C_FETCH);
    nxt();
    chk("ill.decode", C_DEC_ILL);
    nxt();
    chk("ill.next_fetch", C_FETCH);

    // Reset asserted in the middle of a store cycle.
    fetch(6'h2B, 6'h00, "swrst");
    chk("swrst.addr", C_MADDR);
    nxt();
    chk("swrst.wr", C_MWR);
    #2;
    reset = 1'b1;
    #1;
    chk("swrst.async_drop", C_ZERO);
    nxt();
    chk("swrst.held", C_ZERO);
    reset = 1'b0;
    nxt();
    chk("swrst.restart_fetch", C_FETCH);

`ifdef MCTRL_MEM_HANDSHAKE_EN
    fetch(6'h2B, 6'h00, "to");
    chk("to.addr", C_MADDR);
    nxt();
    bus.mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 15; i++) begin
      chk("to.wait", C_MWR_W);
      nxt();
    end
    chk("to.halt", C_HALT);
    bus.mem_ready = 1'b1;
    nxt();
    chk("to.sticky", C_HALT);
    reset = 1'b1;
    #1;
    chk("to.reset_clears", C_ZERO);
    nxt();
    reset = 1'b0;
    nxt();
    chk("to.restart_fetch", C_FETCH);

    fetch(6'h2B, 6'h00, "lim");
    chk("lim.addr", C_MADDR);
    nxt();
    bus.mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 14; i++) begin
      chk("lim.wait", C_MWR_W);
      nxt();
    end
    bus.mem_ready = 1'b1;
    #1;
    chk("lim.ready_on_limit", C_MWR);
    nxt();
    chk("lim.next_fetch", C_FETCH);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the MIPS-subset datapath (R-type incl. sll/srl, lw, sw, beq, bgt, xori, j). Replaces single-cycle decode with a registered state machine that drives the shared ALU, register file, PC and a single unified instruction/data memory over several cycles per instruction. It sits beside the datapath: it takes opcode/funct from the instruction register and ALU flags, and returns per-cycle enables and mux selects. It also enforces a ready-based memory handshake with timeout.

## Interface
- `WAIT_LIMIT`, 15: maximum wait cycles per memory access before timeout.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `opcode`  in  6  IR[31:26].
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU result == 0.
- `gt`  in  1  ALU signed A > B.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `pc_we, ir_we, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a, sign_zero`  out  1 each  datapath controls; `sign_zero`=1 selects zero-extend.
- `alu_src_b`  out  2  00 regB, 01 const 4, 10 ext imm, 11 ext imm<<2.
- `alu_op`  out  2  00 add, 01 sub, 10 funct, 11 xor.
- `pc_src`  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- `instr_done`  out  1  one-cycle pulse in the final state of each instruction.
- `illegal_op`  out  1  one-cycle pulse on an undefined opcode.
- `mem_timeout`  out  1  sticky error flag.

## Operation
- States: RST, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP, HALT.
- RST: all outputs 0; unconditional transition to FETCH.
- FETCH: mem_read=1, i_or_d=0, ir_we=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. pc_we and ir_we are asserted only in the cycle where mem_ready=1. On that cycle → DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precompute branch target). Dispatch on opcode:
  - 0x00 → EXEC_R
  - 0x23/0x2B → MEM_ADDR
  - 0x04/0x05 → BRANCH
  - 0x0E → EXEC_I
  - 0x02 → JUMP
  - any other opcode → FETCH with illegal_op=1 and instr_done=1.
- EXEC_R: alu_src_a=1, alu_op=10. alu_src_b=10 when funct is 0x00 or 0x02 (shift), otherwise 00. → R_WB.
- R_WB: reg_dst=1, reg_write=1, mem_to_reg=0, instr_done=1. → FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00, sign_zero=0. → MEM_RD for lw, MEM_WR for sw.
- MEM_RD: i_or_d=1, mem_read=1. Held until mem_ready, then → MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1. → FETCH.
- MEM_WR: i_or_d=1, mem_write=1. Held until mem_ready; in the ready cycle instr_done=1, then → FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=11, sign_zero=1. → I_WB.
- I_WB: reg_dst=0, reg_write=1, mem_to_reg=0, instr_done=1. → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, instr_done=1.
  - pc_we = zero for beq, gt for bgt (combinational from the flags).
  - → FETCH.
- JUMP: pc_src=10, pc_we=1, instr_done=1. → FETCH.
- Any output not listed for a state is 0.
- HALT: all outputs 0 except mem_timeout. Exited only by reset.

## Timing
- State register updates on the rising edge of clk; reset forces RST asynchronously.
- Outputs are combinational from the state register (Moore). Exceptions: pc_we/ir_we in FETCH and instr_done in MEM_WR are qualified by mem_ready, and pc_we in BRANCH is qualified by the flags.
- Zero-wait memory latencies, counted from FETCH entry:
  - R-type and xori: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq/bgt and j: 3 cycles.
  - illegal opcode: 2 cycles.
- Each cycle of mem_ready=0 in a memory state adds one cycle. Memory controls stay stable while waiting.
- The wait counter clears on entry to each memory state. If it reaches WAIT_LIMIT with mem_ready still 0 → HALT, and mem_timeout=1 from the next cycle. mem_ready arriving on the limit cycle wins: no timeout.
- Reset asserted mid-instruction abandons it: no pc_we/reg_write/mem_write after the asynchronous assertion. mem_timeout clears.

## Configuration
- `MCTRL_MEM_HANDSHAKE_EN` defined: wait states, wait counter, timeout and HALT behave as above.
- Undefined: mem_ready is ignored and treated as 1. The wait counter and HALT are not built, and mem_timeout is tied to 0.

## Structure
- Package `mctrl_pkg` holds:
  - the state enum;
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BGT, OP_XORI, OP_J);
  - funct codes FN_SLL and FN_SRL;
  - the alu_src_b, alu_op and pc_src encodings.
- One sub-module, `mctrl_wait_timer`: clear/enable/expired, width $clog2(WAIT_LIMIT+1), instantiated only under the macro.

## Test plan
- Reset, then an R-type add (funct 0x20) with mem_ready=1: RST→FETCH→DECODE→EXEC_R→R_WB. reg_write=1 and reg_dst=1 only in cycle 4; instr_done pulses once.
- lw with mem_ready low for 3 cycles in MEM_RD: mem_read and i_or_d held for 4 cycles; MEM_WB follows with mem_to_reg=1; total 8 cycles.
- beq with zero=1, then zero=0; bgt with gt=1: pc_we=1 with pc_src=01 in BRANCH exactly when taken.
- Opcode 0x3F: illegal_op and instr_done pulse in DECODE, next state FETCH, no reg_write/mem_write.
- With the macro defined, mem_ready=0 for 15 cycles in MEM_WR: HALT entered, mem_timeout=1 and sticky; reset clears it. mem_ready=1 on cycle 15 gives a normal completion.
- Assert reset during MEM_WR: mem_write drops immediately and the FSM restarts at RST→FETCH.
